// File: rtl/ay_mixer_dac_if.sv
// ay_mixer_dac_if: bundles the sound-core signals feeding the AY output stage
// and the levels / bitstreams it returns. The master side is the upstream
// tone/noise/envelope/register logic; the slave side is ay_mixer_dac.
// The stereo signals exist only when AY_MIX_STEREO_EN is defined.

interface ay_mixer_dac_if;
  logic       ay_clk;
  logic       tone_a;
  logic       tone_b;
  logic       tone_c;
  logic       noise;
  logic [5:0] mixer;
  logic [4:0] amp_a;
  logic [4:0] amp_b;
  logic [4:0] amp_c;
  logic [3:0] env;
  logic [7:0] level_a;
  logic [7:0] level_b;
  logic [7:0] level_c;
  logic [9:0] mix;
  logic       dac_out;
`ifdef AY_MIX_STEREO_EN
  logic [8:0] left_mix;
  logic [8:0] right_mix;
  logic       left_out;
  logic       right_out;
`endif

  modport master (
    output ay_clk, tone_a, tone_b, tone_c, noise, mixer, amp_a, amp_b, amp_c, env,
`ifdef AY_MIX_STEREO_EN
    input  left_mix, right_mix, left_out, right_out,
`endif
    input  level_a, level_b, level_c, mix, dac_out
  );

  modport slave (
    input  ay_clk, tone_a, tone_b, tone_c, noise, mixer, amp_a, amp_b, amp_c, env,
`ifdef AY_MIX_STEREO_EN
    output left_mix, right_mix, left_out, right_out,
`endif
    output level_a, level_b, level_c, mix, dac_out
  );
endinterface

// File: rtl/ay_mixer_dac.sv
// ay_mixer_dac: AY-3-891x output stage. Gates tone/noise through the R7 mixer
// bits, picks fixed or envelope volume, maps it through a ~3 dB/step log
// table, sums the three channels and drives a first-order sigma-delta pin.
// Define AY_MIX_STEREO_EN to add ACB stereo mixes with their own 9-bit
// sigma-delta modulators (left_out / right_out).

module ay_mixer_dac #(
  parameter bit SAMPLE_ON_AY_CLK = 1'b1
) (
  input logic           clk,
  input logic           reset,
  ay_mixer_dac_if.slave bus
);

  // Log volume table: 4-bit AY volume to linear 8-bit level.
  function automatic logic [7:0] vol_to_level(input logic [3:0] vol);
    logic [7:0] lvl;
    case (vol)
      4'd0:    lvl = 8'd0;
      4'd1:    lvl = 8'd2;
      4'd2:    lvl = 8'd3;
      4'd3:    lvl = 8'd4;
      4'd4:    lvl = 8'd6;
      4'd5:    lvl = 8'd8;
      4'd6:    lvl = 8'd11;
      4'd7:    lvl = 8'd16;
      4'd8:    lvl = 8'd23;
      4'd9:    lvl = 8'd32;
      4'd10:   lvl = 8'd45;
      4'd11:   lvl = 8'd64;
      4'd12:   lvl = 8'd90;
      4'd13:   lvl = 8'd128;
      4'd14:   lvl = 8'd180;
      4'd15:   lvl = 8'd255;
      default: lvl = 8'd0;
    endcase
    return lvl;
  endfunction

  logic       cap_en_s;
  logic [2:0] gate_next_s;
  logic [3:0] vol_a_next_s;
  logic [3:0] vol_b_next_s;
  logic [3:0] vol_c_next_s;
  logic [2:0] gate_r;
  logic [3:0] vol_a_r;
  logic [3:0] vol_b_r;
  logic [3:0] vol_c_r;
  logic [7:0] level_a_r;
  logic [7:0] level_b_r;
  logic [7:0] level_c_r;
  logic [9:0] mix_r;
  logic [9:0] acc_r;
  logic       dac_r;
  logic [10:0] sd_sum_s;

  // Stage-1 combinational: capture enable, per-channel gate and volume select.
  always_comb begin
    cap_en_s     = 1'b1;
    gate_next_s  = 3'b000;
    vol_a_next_s = 4'd0;
    vol_b_next_s = 4'd0;
    vol_c_next_s = 4'd0;
    if (SAMPLE_ON_AY_CLK) begin
      cap_en_s = bus.ay_clk;
    end else begin
      cap_en_s = 1'b1;
    end
    // A disabled source forces its term high, so a fully disabled channel
    // passes its volume straight through (sample playback).
    gate_next_s[0] = (bus.tone_a | bus.mixer[0]) & (bus.noise | bus.mixer[3]);
    gate_next_s[1] = (bus.tone_b | bus.mixer[1]) & (bus.noise | bus.mixer[4]);
    gate_next_s[2] = (bus.tone_c | bus.mixer[2]) & (bus.noise | bus.mixer[5]);
    vol_a_next_s   = bus.amp_a[4] ? bus.env : bus.amp_a[3:0];
    vol_b_next_s   = bus.amp_b[4] ? bus.env : bus.amp_b[3:0];
    vol_c_next_s   = bus.amp_c[4] ? bus.env : bus.amp_c[3:0];
  end

  // Stage 1: capture gate and volume on enabled cycles, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_r  <= 3'b000;
      vol_a_r <= 4'd0;
      vol_b_r <= 4'd0;
      vol_c_r <= 4'd0;
    end else if (cap_en_s) begin
      gate_r  <= gate_next_s;
      vol_a_r <= vol_a_next_s;
      vol_b_r <= vol_b_next_s;
      vol_c_r <= vol_c_next_s;
    end else begin
      gate_r  <= gate_r;
      vol_a_r <= vol_a_r;
      vol_b_r <= vol_b_r;
      vol_c_r <= vol_c_r;
    end
  end

  // Stage 2: gated linear channel levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_a_r <= 8'd0;
      level_b_r <= 8'd0;
      level_c_r <= 8'd0;
    end else begin
      level_a_r <= gate_r[0] ? vol_to_level(vol_a_r) : 8'd0;
      level_b_r <= gate_r[1] ? vol_to_level(vol_b_r) : 8'd0;
      level_c_r <= gate_r[2] ? vol_to_level(vol_c_r) : 8'd0;
    end
  end

  // Stage 3: mono sum, at most 3*255 = 765 so 10 bits never overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_r <= 10'd0;
    end else begin
      mix_r <= {2'b00, level_a_r} + {2'b00, level_b_r} + {2'b00, level_c_r};
    end
  end

  // Sigma-delta adder: the carry out of a modulo-1024 accumulator is the bit.
  always_comb begin
    sd_sum_s = {1'b0, acc_r} + {1'b0, mix_r};
  end

  // Mono sigma-delta state: accumulator wraps freely, carry drives the pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r <= 10'd0;
      dac_r <= 1'b0;
    end else begin
      acc_r <= sd_sum_s[9:0];
      dac_r <= sd_sum_s[10];
    end
  end

  assign bus.level_a = level_a_r;
  assign bus.level_b = level_b_r;
  assign bus.level_c = level_c_r;
  assign bus.mix     = mix_r;
  assign bus.dac_out = dac_r;

`ifdef AY_MIX_STEREO_EN
  logic [8:0] left_mix_r;
  logic [8:0] right_mix_r;
  logic [8:0] left_acc_r;
  logic [8:0] right_acc_r;
  logic       left_dac_r;
  logic       right_dac_r;
  logic [9:0] left_sum_s;
  logic [9:0] right_sum_s;

  // ACB stereo mixes: B is shared half-level between both sides (max 382).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_mix_r  <= 9'd0;
      right_mix_r <= 9'd0;
    end else begin
      left_mix_r  <= {1'b0, level_a_r} + {2'b00, level_b_r[7:1]};
      right_mix_r <= {1'b0, level_c_r} + {2'b00, level_b_r[7:1]};
    end
  end

  // Stereo sigma-delta adders, modulo-512 accumulators.
  always_comb begin
    left_sum_s  = {1'b0, left_acc_r} + {1'b0, left_mix_r};
    right_sum_s = {1'b0, right_acc_r} + {1'b0, right_mix_r};
  end

  // Stereo sigma-delta state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_acc_r  <= 9'd0;
      right_acc_r <= 9'd0;
      left_dac_r  <= 1'b0;
      right_dac_r <= 1'b0;
    end else begin
      left_acc_r  <= left_sum_s[8:0];
      right_acc_r <= right_sum_s[8:0];
      left_dac_r  <= left_sum_s[9];
      right_dac_r <= right_sum_s[9];
    end
  end

  assign bus.left_mix  = left_mix_r;
  assign bus.right_mix = right_mix_r;
  assign bus.left_out  = left_dac_r;
  assign bus.right_out = right_dac_r;
`endif

endmodule

// File: tb/tb_ay_mixer_dac.sv
// tb_ay_mixer_dac: scoreboard bench for ay_mixer_dac. Each driven cycle pushes
// the expected levels and mix; a monitor pops and compares them when due.
// Scenario tasks add inline checks for reset, gating and DAC density.

module tb_ay_mixer_dac;

  typedef struct {
    int         due;
    logic [7:0] la;
    logic [7:0] lb;
    logic [7:0] lc;
  } lvl_item_t;

  typedef struct {
    int         due;
    logic [9:0] m;
    logic [8:0] lm;
    logic [8:0] rm;
  } mix_item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clk_run = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  logic [7:0] lut_tab [16] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
                               8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd180, 8'd255};

  lvl_item_t lvl_q[$];
  mix_item_t mix_q[$];
  logic       cap_gate [3];
  logic [3:0] cap_vol  [3];

  ay_mixer_dac_if bus();

  ay_mixer_dac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Scoreboard monitor: count edges and compare entries that fall due.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    while (lvl_q.size() > 0 && lvl_q[0].due <= cyc) begin
      if (lvl_q[0].due == cyc) begin
        total++;
        if (bus.level_a !== lvl_q[0].la || bus.level_b !== lvl_q[0].lb || bus.level_c !== lvl_q[0].lc) begin
          bad++;
          $display("FAIL sb_levels cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc,
                   bus.level_a, bus.level_b, bus.level_c, lvl_q[0].la, lvl_q[0].lb, lvl_q[0].lc);
        end
      end
      void'(lvl_q.pop_front());
    end
    while (mix_q.size() > 0 && mix_q[0].due <= cyc) begin
      if (mix_q[0].due == cyc) begin
        total++;
        if (bus.mix !== mix_q[0].m) begin
          bad++;
          $display("FAIL sb_mix cyc=%0d got=%0d exp=%0d", cyc, bus.mix, mix_q[0].m);
        end
`ifdef AY_MIX_STEREO_EN
        total++;
        if (bus.left_mix !== mix_q[0].lm || bus.right_mix !== mix_q[0].rm) begin
          bad++;
          $display("FAIL sb_stereo cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                   bus.left_mix, bus.right_mix, mix_q[0].lm, mix_q[0].rm);
        end
`endif
      end
      void'(mix_q.pop_front());
    end
  end

  task automatic flush_model();
    lvl_q.delete();
    mix_q.delete();
    for (int i = 0; i < 3; i++) begin
      cap_gate[i] = 1'b0;
      cap_vol[i]  = 4'd0;
    end
  endtask

  // Drive n cycles: model the capture at the coming edge and push expectations.
  task automatic step(input int n);
    lvl_item_t li;
    mix_item_t mi;
    for (int i = 0; i < n; i++) begin
      if (bus.ay_clk) begin
        cap_gate[0] = (bus.tone_a | bus.mixer[0]) & (bus.noise | bus.mixer[3]);
        cap_gate[1] = (bus.tone_b | bus.mixer[1]) & (bus.noise | bus.mixer[4]);
        cap_gate[2] = (bus.tone_c | bus.mixer[2]) & (bus.noise | bus.mixer[5]);
        cap_vol[0]  = bus.amp_a[4] ? bus.env : bus.amp_a[3:0];
        cap_vol[1]  = bus.amp_b[4] ? bus.env : bus.amp_b[3:0];
        cap_vol[2]  = bus.amp_c[4] ? bus.env : bus.amp_c[3:0];
      end
      li.due = cyc + 2;
      li.la  = cap_gate[0] ? lut_tab[cap_vol[0]] : 8'd0;
      li.lb  = cap_gate[1] ? lut_tab[cap_vol[1]] : 8'd0;
      li.lc  = cap_gate[2] ? lut_tab[cap_vol[2]] : 8'd0;
      mi.due = cyc + 3;
      mi.m   = 10'(li.la) + 10'(li.lb) + 10'(li.lc);
      mi.lm  = 9'(li.la) + 9'(li.lb >> 1);
      mi.rm  = 9'(li.lc) + 9'(li.lb >> 1);
      lvl_q.push_back(li);
      mix_q.push_back(mi);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_inputs(input logic [5:0] mx, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] c);
    bus.mixer = mx;
    bus.amp_a = a;
    bus.amp_b = b;
    bus.amp_c = c;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.level_a !== 8'd0 || bus.mix !== 10'd0 || bus.dac_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%0d/%0d/%0d exp=0/0/0", bus.level_a, bus.mix, bus.dac_out);
    end
    reset = 1'b0;
    flush_model();
    set_inputs(6'h3F, 5'h0F, 5'h00, 5'h00);
    step(8);
    total++;
    if (bus.level_a !== 8'd255 || bus.mix !== 10'd255) begin
      bad++;
      $display("FAIL pre_reset got=%0d/%0d exp=255/255", bus.level_a, bus.mix);
    end
    // Stop the clock, then reset must clear outputs with no edge.
    @(negedge clk);
    clk_run = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (bus.level_a !== 8'd0 || bus.mix !== 10'd0 || bus.dac_out !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=%0d/%0d/%0d exp=0/0/0", bus.level_a, bus.mix, bus.dac_out);
    end
    #2;
    reset = 1'b0;
    set_inputs(6'h3F, 5'h00, 5'h00, 5'h00);
    flush_model();
    clk_run = 1'b1;
    step(6);
    total++;
    if (bus.level_a !== 8'd0 || bus.level_b !== 8'd0 || bus.level_c !== 8'd0 ||
        bus.mix !== 10'd0 || bus.dac_out !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_hold got=%0d/%0d/%0d/%0d/%0d exp=0", bus.level_a, bus.level_b,
               bus.level_c, bus.mix, bus.dac_out);
    end
  endtask

  task automatic test_dac_density(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                  input int exp_ones);
    int   ones;
    logic seen_zero;
    ones = 0;
    seen_zero = 1'b0;
    set_inputs(6'h3F, a, b, c);
    step(6);
    for (int i = 0; i < 1024; i++) begin
      step(1);
      if (bus.dac_out === 1'b1) ones++;
      else seen_zero = 1'b1;
    end
    total++;
    if (ones != exp_ones) begin
      bad++;
      $display("FAIL dac_density got=%0d exp=%0d", ones, exp_ones);
    end
    total++;
    if (!seen_zero) begin
      bad++;
      $display("FAIL dac_not_constant got=all_ones exp=some_zero mix=%0d", bus.mix);
    end
  endtask

  task automatic test_tone_gate();
    set_inputs(6'h3E, 5'h0F, 5'h00, 5'h00);
    for (int p = 0; p < 6; p++) begin
      bus.tone_a = ~bus.tone_a;
      step(8);
      total++;
      if (bus.level_a !== (bus.tone_a ? 8'd255 : 8'd0)) begin
        bad++;
        $display("FAIL tone_gate got=%0d exp=%0d", bus.level_a, bus.tone_a ? 255 : 0);
      end
    end
    bus.tone_a = 1'b0;
  endtask

  task automatic test_env();
    set_inputs(6'h3F, 5'h00, 5'h10, 5'h00);
    for (int v = 0; v < 16; v++) begin
      bus.env = 4'(v);
      step(3);
      total++;
      if (bus.level_b !== lut_tab[v]) begin
        bad++;
        $display("FAIL env_lut vol=%0d got=%0d exp=%0d", v, bus.level_b, lut_tab[v]);
      end
    end
    bus.env = 4'd0;
  endtask

  task automatic test_noise();
    set_inputs(6'h1F, 5'h00, 5'h00, 5'h0C);
    bus.noise = 1'b0;
    step(4);
    total++;
    if (bus.level_c !== 8'd0) begin
      bad++;
      $display("FAIL noise_low got=%0d exp=0", bus.level_c);
    end
    bus.noise = 1'b1;
    step(4);
    total++;
    if (bus.level_c !== 8'd90) begin
      bad++;
      $display("FAIL noise_high got=%0d exp=90", bus.level_c);
    end
    bus.noise = 1'b0;
  endtask

  task automatic test_ay_clk_hold();
    set_inputs(6'h3F, 5'h08, 5'h00, 5'h00);
    bus.ay_clk = 1'b1;
    step(1);
    bus.ay_clk = 1'b0;
    step(7);
    bus.amp_a = 5'h0F;
    step(5);
    total++;
    if (bus.level_a !== 8'd23) begin
      bad++;
      $display("FAIL ay_clk_hold got=%0d exp=23", bus.level_a);
    end
    bus.ay_clk = 1'b1;
    step(1);
    bus.ay_clk = 1'b0;
    step(1);
    total++;
    if (bus.level_a !== 8'd255) begin
      bad++;
      $display("FAIL ay_clk_update got=%0d exp=255", bus.level_a);
    end
    step(6);
    bus.ay_clk = 1'b1;
  endtask

  initial begin
    bus.ay_clk = 1'b1;
    bus.tone_a = 1'b0;
    bus.tone_b = 1'b0;
    bus.tone_c = 1'b0;
    bus.noise  = 1'b0;
    bus.mixer  = 6'h00;
    bus.amp_a  = 5'h00;
    bus.amp_b  = 5'h00;
    bus.amp_c  = 5'h00;
    bus.env    = 4'd0;
    flush_model();
    test_reset();
    test_dac_density(5'h0F, 5'h00, 5'h00, 255);
    test_tone_gate();
    test_env();
    test_noise();
    test_ay_clk_hold();
    test_dac_density(5'h0F, 5'h0F, 5'h0F, 765);
    test_dac_density(5'h00, 5'h00, 5'h00, 0);
    step(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
